// File: rtl/sched_in_pkt_fifo.sv
// Store-and-forward packet FIFO feeding the task scheduler core; packets become visible only once complete.
// Optional build macro SCHED_IN_PKT_FIFO_TID_CHECK_EN: drop any packet whose tid changes mid-packet.
module sched_in_pkt_fifo #(
    parameter int ID_WIDTH  = 4,
    parameter int DEPTH     = 64,
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic [63:0]          S_AXIS_tdata,
    input  logic [ID_WIDTH-1:0]  S_AXIS_tid,
    input  logic                 S_AXIS_tlast,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic [63:0]          M_AXIS_tdata,
    output logic [ID_WIDTH-1:0]  M_AXIS_tid,
    output logic                 M_AXIS_tlast,
    output logic                 drop_pulse,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = 64 + ID_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

    typedef enum logic {ACCEPT, DROP} wr_state_t;
    wr_state_t state;

    logic [WW-1:0]        mem [DEPTH];
    logic [CNT_WIDTH-1:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
    logic [CNT_WIDTH-1:0] occupancy, wr_ptr_inc, pkt_len;
    logic                 ready_en;
    logic                 in_hs, wr_en, oversize, tid_bad, drop_now, pkt_commit;

    // rd_ptr retires words only on the output handshake, so words held in
    // the output pipeline still count against capacity.
    assign occupancy     = wr_ptr - rd_ptr;
    assign wr_ptr_inc    = wr_ptr + 1'b1;
    assign pkt_len       = wr_ptr_inc - commit_ptr;
    assign S_AXIS_tready = ready_en && (state == DROP || occupancy < DEPTH_C);
    assign in_hs         = S_AXIS_tvalid && S_AXIS_tready;
    assign wr_en         = in_hs && state == ACCEPT;
    assign oversize      = !S_AXIS_tlast && pkt_len == DEPTH_C;

`ifdef SCHED_IN_PKT_FIFO_TID_CHECK_EN
    logic [ID_WIDTH-1:0] first_tid;

    // wr_ptr == commit_ptr in ACCEPT means this word opens a new packet.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ptr == commit_ptr) first_tid <= S_AXIS_tid;
    end

    assign tid_bad = wr_ptr != commit_ptr && S_AXIS_tid != first_tid;
`else
    assign tid_bad = 1'b0;
`endif

    assign drop_now   = wr_en && (oversize || tid_bad);
    assign pkt_commit = wr_en && S_AXIS_tlast && !tid_bad;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ACCEPT;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            drop_pulse <= 1'b0;
            ready_en   <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            drop_pulse <= drop_now;
            case (state)
                ACCEPT: begin
                    if (wr_en) begin
                        if (drop_now) begin
                            wr_ptr <= commit_ptr;
                            if (!S_AXIS_tlast) state <= DROP;
                        end else begin
                            wr_ptr <= wr_ptr_inc;
                            if (S_AXIS_tlast) commit_ptr <= wr_ptr_inc;
                        end
                    end
                end
                DROP: begin
                    if (in_hs && S_AXIS_tlast) state <= ACCEPT;
                end
                default: state <= ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {S_AXIS_tlast, S_AXIS_tid, S_AXIS_tdata};
    end

    // p0: prefetch register loaded from RAM; p1: output register.
    logic [WW-1:0] word_p0, word_p1;
    logic          vld_p0, vld_p1;
    logic          fetch, load_p1, out_hs;

    assign out_hs  = vld_p1 && M_AXIS_tready;
    assign load_p1 = vld_p0 && (!vld_p1 || M_AXIS_tready);
    assign fetch   = fetch_ptr != commit_ptr && (!vld_p0 || load_p1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_ptr <= '0;
            rd_ptr    <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (fetch) fetch_ptr <= fetch_ptr + 1'b1;
            if (out_hs) rd_ptr <= rd_ptr + 1'b1;

            if (fetch) vld_p0 <= 1'b1;
            else if (load_p1) vld_p0 <= 1'b0;

            if (load_p1) vld_p1 <= 1'b1;
            else if (out_hs) vld_p1 <= 1'b0;

            case ({pkt_commit, out_hs && M_AXIS_tlast})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fetch) word_p0 <= mem[fetch_ptr[AW-1:0]];
        if (load_p1) word_p1 <= word_p0;
    end

    assign M_AXIS_tvalid = vld_p1;
    assign {M_AXIS_tlast, M_AXIS_tid, M_AXIS_tdata} = word_p1;

endmodule

// File: tb/tb_sched_in_pkt_fifo.sv
// Self-checking bench for sched_in_pkt_fifo (DEPTH=8): directed scenarios plus randomized traffic
// against a queue-based packet model.
`timescale 1ns/1ps
module tb_sched_in_pkt_fifo;
    localparam int ID_WIDTH  = 4;
    localparam int DEPTH     = 8;
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
`ifdef SCHED_IN_PKT_FIFO_TID_CHECK_EN
    localparam bit TID_CHK = 1'b1;
`else
    localparam bit TID_CHK = 1'b0;
`endif

    typedef struct packed {
        logic                last;
        logic [ID_WIDTH-1:0] tid;
        logic [63:0]         data;
    } word_t;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 S_AXIS_tvalid = 1'b0;
    logic                 S_AXIS_tready;
    logic [63:0]          S_AXIS_tdata = '0;
    logic [ID_WIDTH-1:0]  S_AXIS_tid = '0;
    logic                 S_AXIS_tlast = 1'b0;
    logic                 M_AXIS_tvalid;
    logic                 M_AXIS_tready = 1'b0;
    logic [63:0]          M_AXIS_tdata;
    logic [ID_WIDTH-1:0]  M_AXIS_tid;
    logic                 M_AXIS_tlast;
    logic                 drop_pulse;
    logic [CNT_WIDTH-1:0] pkt_count;

    always #5 clk = ~clk;

    sched_in_pkt_fifo #(.ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rstn(rstn),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready), .S_AXIS_tdata(S_AXIS_tdata),
        .S_AXIS_tid(S_AXIS_tid), .S_AXIS_tlast(S_AXIS_tlast),
        .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready), .M_AXIS_tdata(M_AXIS_tdata),
        .M_AXIS_tid(M_AXIS_tid), .M_AXIS_tlast(M_AXIS_tlast),
        .drop_pulse(drop_pulse), .pkt_count(pkt_count)
    );

    // Reference model: committed packets awaiting readout, the packet being received, drop mode.
    word_t m_fifo[$];
    word_t m_part[$];
    bit    m_drop, m_in_rst, exp_drop;
    int    m_pkts;

    // Values sampled just before each rising edge.
    bit    pre_rdy_exp, pre_rdy_dut, pre_vld, pre_have, pre_out_hs, pre_in_hs;
    word_t pre_out, pre_front;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic set_in(input bit v, input logic [63:0] d, input logic [ID_WIDTH-1:0] t, input bit l);
        S_AXIS_tvalid = v;
        S_AXIS_tdata  = d;
        S_AXIS_tid    = t;
        S_AXIS_tlast  = l;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        S_AXIS_tvalid = 1'b0;
        m_fifo.delete();
        m_part.delete();
        m_drop   = 1'b0;
        m_pkts   = 0;
        m_in_rst = 1'b1;
        exp_drop = 1'b0;
    endtask

    // Advance one clock, updating the model from the sampled handshakes; returns at posedge+1.
    task automatic tick();
        word_t inw;
        #2;
        pre_rdy_exp = !m_in_rst && (m_drop || (m_fifo.size() + m_part.size() < DEPTH));
        pre_rdy_dut = S_AXIS_tready;
        pre_vld     = M_AXIS_tvalid;
        pre_out     = {M_AXIS_tlast, M_AXIS_tid, M_AXIS_tdata};
        pre_have    = m_fifo.size() > 0;
        pre_front   = pre_have ? m_fifo[0] : '0;
        pre_out_hs  = M_AXIS_tvalid && M_AXIS_tready;
        pre_in_hs   = S_AXIS_tvalid && pre_rdy_exp;
        inw         = {S_AXIS_tlast, S_AXIS_tid, S_AXIS_tdata};
        @(posedge clk);
        m_in_rst = !rstn;
        exp_drop = 1'b0;
        if (pre_out_hs && pre_have) begin
            if (m_fifo[0].last) m_pkts--;
            void'(m_fifo.pop_front());
        end
        if (pre_in_hs) begin
            if (m_drop) begin
                if (inw.last) m_drop = 1'b0;
            end else if (TID_CHK && m_part.size() > 0 && inw.tid != m_part[0].tid) begin
                m_part.delete();
                exp_drop = 1'b1;
                m_drop   = !inw.last;
            end else begin
                m_part.push_back(inw);
                if (inw.last) begin
                    foreach (m_part[k]) m_fifo.push_back(m_part[k]);
                    m_part.delete();
                    m_pkts++;
                end else if (m_part.size() == DEPTH) begin
                    m_part.delete();
                    m_drop   = 1'b1;
                    exp_drop = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) tick();
        n_vec++; if (S_AXIS_tready !== 1'b0) begin n_fail++; $display("FAIL rst_tready: got %b want 0", S_AXIS_tready); end
        n_vec++; if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", M_AXIS_tvalid); end
        n_vec++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_drop: got %b want 0", drop_pulse); end
        n_vec++; if (pkt_count !== '0) begin n_fail++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
        rstn = 1'b1;
        tick();
        n_vec++; if (pre_rdy_dut !== 1'b0) begin n_fail++; $display("FAIL rst_rel_tready0: got %b want 0", pre_rdy_dut); end
        n_vec++; if (S_AXIS_tready !== 1'b1) begin n_fail++; $display("FAIL rst_rel_tready1: got %b want 1", S_AXIS_tready); end
    endtask

    task automatic test_back_to_back();
        word_t exp;
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 64'h11 * 64'(i + 1), 4'd2, i == 2);
            tick();
            n_vec++; if (pre_rdy_dut !== 1'b1) begin n_fail++; $display("FAIL b2b_tready[%0d]: got %b want 1", i, pre_rdy_dut); end
        end
        set_in(1'b0, '0, '0, 1'b0);
        n_vec++; if (pkt_count !== CNT_WIDTH'(1)) begin n_fail++; $display("FAIL b2b_cnt_up: got %0d want 1", pkt_count); end
        n_vec++; if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_lat0: got %b want 0", M_AXIS_tvalid); end
        tick();
        n_vec++; if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_lat1: got %b want 0", M_AXIS_tvalid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {i == 2, 4'd2, 64'h11 * 64'(i + 1)};
            n_vec++;
            if (M_AXIS_tvalid !== 1'b1 || {M_AXIS_tlast, M_AXIS_tid, M_AXIS_tdata} !== exp) begin
                n_fail++;
                $display("FAIL b2b_word[%0d]: got v=%b %h want v=1 %h", i, M_AXIS_tvalid, {M_AXIS_tlast, M_AXIS_tid, M_AXIS_tdata}, exp);
            end
        end
        tick();
        n_vec++; if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end_vld: got %b want 0", M_AXIS_tvalid); end
        n_vec++; if (pkt_count !== '0) begin n_fail++; $display("FAIL b2b_cnt_down: got %0d want 0", pkt_count); end
    endtask

    task automatic test_store_forward();
        word_t exp;
        M_AXIS_tready = 1'b1;
        set_in(1'b1, 64'hA1, 4'd3, 1'b0); tick();
        set_in(1'b1, 64'hA2, 4'd3, 1'b0); tick();
        set_in(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL sf_hold[%0d]: got %b want 0", i, M_AXIS_tvalid); end
        end
        set_in(1'b1, 64'hA3, 4'd3, 1'b1); tick();
        set_in(1'b0, '0, '0, 1'b0);
        n_vec++; if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL sf_lat0: got %b want 0", M_AXIS_tvalid); end
        tick();
        n_vec++; if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL sf_lat1: got %b want 0", M_AXIS_tvalid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = {i == 2, 4'd3, 64'hA1 + 64'(i)};
            n_vec++;
            if (M_AXIS_tvalid !== 1'b1 || {M_AXIS_tlast, M_AXIS_tid, M_AXIS_tdata} !== exp) begin
                n_fail++;
                $display("FAIL sf_word[%0d]: got v=%b %h want v=1 %h", i, M_AXIS_tvalid, {M_AXIS_tlast, M_AXIS_tid, M_AXIS_tdata}, exp);
            end
        end
        tick();
    endtask

    task automatic test_oversize();
        word_t got[$];
        word_t exp, act;
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 64'hE0 + 64'(i), 4'd5, i == 11);
            tick();
            if (pre_out_hs) got.push_back(pre_out);
            n_vec++; if (pre_rdy_dut !== 1'b1) begin n_fail++; $display("FAIL ovs_tready[%0d]: got %b want 1", i, pre_rdy_dut); end
            n_vec++; if (drop_pulse !== (i == 7)) begin n_fail++; $display("FAIL ovs_drop[%0d]: got %b want %b", i, drop_pulse, i == 7); end
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 64'hB0 + 64'(i), 4'd6, i == 1);
            tick();
            if (pre_out_hs) got.push_back(pre_out);
        end
        set_in(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pre_out_hs) got.push_back(pre_out);
        end
        n_vec++; if (got.size() != 2) begin n_fail++; $display("FAIL ovs_count: got %0d words want 2", got.size()); end
        for (int i = 0; i < 2; i++) begin
            exp = {i == 1, 4'd6, 64'hB0 + 64'(i)};
            act = (got.size() > i) ? got[i] : 'x;
            n_vec++; if (act !== exp) begin n_fail++; $display("FAIL ovs_word[%0d]: got %h want %h", i, act, exp); end
        end
    endtask

    task automatic test_backpressure();
        word_t got[$];
        word_t exp, act;
        M_AXIS_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 64'hC0 + 64'(i), (i < 4) ? 4'd8 : 4'd9, (i % 4) == 3);
            tick();
            n_vec++; if (pre_rdy_dut !== 1'b1) begin n_fail++; $display("FAIL bp_tready[%0d]: got %b want 1", i, pre_rdy_dut); end
        end
        set_in(1'b1, 64'hCF, 4'd9, 1'b1);
        tick();
        n_vec++; if (pre_rdy_dut !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b want 0", pre_rdy_dut); end
        set_in(1'b0, '0, '0, 1'b0);
        n_vec++; if (pkt_count !== CNT_WIDTH'(2)) begin n_fail++; $display("FAIL bp_pkt_count: got %0d want 2", pkt_count); end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp = {1'b0, 4'd8, 64'hC0};
            n_vec++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL bp_drop[%0d]: got %b want 0", i, drop_pulse); end
            n_vec++;
            if (M_AXIS_tvalid !== 1'b1 || {M_AXIS_tlast, M_AXIS_tid, M_AXIS_tdata} !== exp) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", i, M_AXIS_tvalid, {M_AXIS_tlast, M_AXIS_tid, M_AXIS_tdata}, exp);
            end
        end
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < 30 && got.size() < 8; i++) begin
            tick();
            if (pre_out_hs) got.push_back(pre_out);
        end
        n_vec++; if (got.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d words want 8", got.size()); end
        for (int i = 0; i < 8; i++) begin
            exp = {(i % 4) == 3, (i < 4) ? 4'd8 : 4'd9, 64'hC0 + 64'(i)};
            act = (got.size() > i) ? got[i] : 'x;
            n_vec++; if (act !== exp) begin n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, act, exp); end
        end
        n_vec++; if (pkt_count !== '0) begin n_fail++; $display("FAIL bp_cnt_end: got %0d want 0", pkt_count); end
    endtask

    task automatic test_reset_mid_packet();
        word_t got[$];
        word_t exp, act;
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 64'hD0 + 64'(i), 4'd4, 1'b0);
            tick();
        end
        do_reset();
        #1;
        n_vec++; if (M_AXIS_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmp_tvalid: got %b want 0", M_AXIS_tvalid); end
        n_vec++; if (pkt_count !== '0) begin n_fail++; $display("FAIL rmp_pkt_count: got %0d want 0", pkt_count); end
        n_vec++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL rmp_drop: got %b want 0", drop_pulse); end
        tick();
        rstn = 1'b1;
        tick();
        n_vec++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL rmp_drop_rel: got %b want 0", drop_pulse); end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 64'hF0 + 64'(i), 4'd1, i == 2);
            tick();
            if (pre_out_hs) got.push_back(pre_out);
        end
        set_in(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pre_out_hs) got.push_back(pre_out);
        end
        n_vec++; if (got.size() != 3) begin n_fail++; $display("FAIL rmp_count: got %0d words want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            exp = {i == 2, 4'd1, 64'hF0 + 64'(i)};
            act = (got.size() > i) ? got[i] : 'x;
            n_vec++; if (act !== exp) begin n_fail++; $display("FAIL rmp_word[%0d]: got %h want %h", i, act, exp); end
        end
    endtask

    task automatic test_tid_check();
        word_t got[$];
        logic [ID_WIDTH-1:0] tids [3];
        tids[0] = 4'd1; tids[1] = 4'd1; tids[2] = 4'd3;
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 64'h71 + 64'(i), tids[i], i == 2);
            tick();
            if (pre_out_hs) got.push_back(pre_out);
`ifdef SCHED_IN_PKT_FIFO_TID_CHECK_EN
            n_vec++; if (drop_pulse !== (i == 2)) begin n_fail++; $display("FAIL tid_drop[%0d]: got %b want %b", i, drop_pulse, i == 2); end
`else
            n_vec++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL tid_nodrop[%0d]: got %b want 0", i, drop_pulse); end
`endif
        end
        set_in(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pre_out_hs) got.push_back(pre_out);
        end
        n_vec++; if (pkt_count !== '0) begin n_fail++; $display("FAIL tid_pkt_count: got %0d want 0", pkt_count); end
`ifdef SCHED_IN_PKT_FIFO_TID_CHECK_EN
        n_vec++; if (got.size() != 0) begin n_fail++; $display("FAIL tid_output: got %0d words want 0", got.size()); end
`else
        n_vec++; if (got.size() != 3) begin n_fail++; $display("FAIL tid_output: got %0d words want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (got.size() <= i || got[i] !== {i == 2, tids[i], 64'h71 + 64'(i)}) begin
                n_fail++;
                $display("FAIL tid_word[%0d]: got %h want %h", i, (got.size() > i) ? got[i] : 'x, {i == 2, tids[i], 64'h71 + 64'(i)});
            end
        end
`endif
    endtask

    task automatic test_random();
        int                  plen, widx;
        logic [ID_WIDTH-1:0] ptid, wtid;
        bit                  prev_stall;
        word_t               prev_out;
        plen = $urandom_range(1, 4);
        widx = 0;
        ptid = ID_WIDTH'($urandom);
        prev_stall = 1'b0;
        prev_out = '0;
        for (int c = 0; c < 600; c++) begin
            wtid = ($urandom_range(0, 11) == 0) ? (ptid ^ 4'h1) : ptid;
            set_in($urandom_range(0, 9) < 7, {$urandom, $urandom}, wtid, widx == plen - 1);
            M_AXIS_tready = $urandom_range(0, 9) < 7;
            tick();
            n_vec++; if (pre_rdy_dut !== pre_rdy_exp) begin n_fail++; $display("FAIL rnd_tready[%0d]: got %b want %b", c, pre_rdy_dut, pre_rdy_exp); end
            if (pre_vld) begin
                n_vec++;
                if (!pre_have || pre_out !== pre_front) begin
                    n_fail++;
                    $display("FAIL rnd_word[%0d]: got %h want %h (model has %0d)", c, pre_out, pre_front, pre_have);
                end
            end
            if (prev_stall) begin
                n_vec++;
                if (!pre_vld || pre_out !== prev_out) begin
                    n_fail++;
                    $display("FAIL rnd_stable[%0d]: got v=%b %h want v=1 %h", c, pre_vld, pre_out, prev_out);
                end
            end
            prev_stall = pre_vld && !M_AXIS_tready;
            prev_out   = pre_out;
            n_vec++; if (drop_pulse !== exp_drop) begin n_fail++; $display("FAIL rnd_drop[%0d]: got %b want %b", c, drop_pulse, exp_drop); end
            n_vec++; if (pkt_count !== CNT_WIDTH'(m_pkts)) begin n_fail++; $display("FAIL rnd_pkt_count[%0d]: got %0d want %0d", c, pkt_count, m_pkts); end
            if (pre_in_hs) begin
                widx++;
                if (widx == plen) begin
                    widx = 0;
                    plen = ($urandom_range(0, 6) == 0) ? int'($urandom_range(DEPTH - 1, DEPTH + 3)) : int'($urandom_range(1, 4));
                    ptid = ID_WIDTH'($urandom);
                end
            end
        end
        set_in(1'b0, '0, '0, 1'b0);
        M_AXIS_tready = 1'b1;
        for (int i = 0; i < 60 && (m_fifo.size() > 0 || M_AXIS_tvalid); i++) begin
            tick();
            if (pre_vld) begin
                n_vec++;
                if (!pre_have || pre_out !== pre_front) begin
                    n_fail++;
                    $display("FAIL rnd_drain_word[%0d]: got %h want %h", i, pre_out, pre_front);
                end
            end
        end
        n_vec++;
        if (m_fifo.size() != 0 || M_AXIS_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_drain: got %0d words left, tvalid=%b want 0, 0", m_fifo.size(), M_AXIS_tvalid);
        end
        n_vec++; if (pkt_count !== '0) begin n_fail++; $display("FAIL rnd_pkt_count_end: got %0d want 0", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_store_forward();
        test_oversize();
        test_backpressure();
        test_reset_mid_packet();
        test_tid_check();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
